// File: rtl/sysid_uptime_slave.sv
// Avalon-MM system-ID slave: constant ID/timestamp words and a 64-bit uptime counter
// read atomically via a hi-shadow latch. Optional scratch register under SYSID_SCRATCH_EN.
module sysid_uptime_slave #(
  parameter logic [31:0] ID_VALUE     = 32'hCAFE0001,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned PRESCALE     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [15:0] PscLast = 16'(PRESCALE - 1);

  logic        rd_acc;
  logic        wr_acc;
  logic        clr;
  logic        tick;
  logic [15:0] psc_q, psc_d;
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] scratch_rd;
  logic [31:0] rd_mux;

  // A simultaneous read wins; the write half of the access is dropped.
  assign rd_acc = chipselect & read;
  assign wr_acc = chipselect & write & ~read;
  assign clr    = wr_acc && (address == 3'd5) && byteenable[0] && writedata[0];

  always_comb begin
    tick     = (psc_q == PscLast);
    psc_d    = tick ? 16'd0 : psc_q + 16'd1;
    uptime_d = tick ? uptime_q + 64'd1 : uptime_q;
    if (clr) begin
      psc_d    = 16'd0;
      uptime_d = 64'd0;
    end
  end

  // Low-word read captures the high word of the same cycle, so a later carry cannot tear it.
  assign hi_shadow_d = (rd_acc && (address == 3'd2)) ? uptime_q[63:32] : hi_shadow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      psc_q       <= 16'd0;
      uptime_q    <= 64'd0;
      hi_shadow_q <= 32'd0;
    end else begin
      psc_q       <= psc_d;
      uptime_q    <= uptime_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

`ifdef SYSID_SCRATCH_EN
  logic [31:0] scratch_q, scratch_d;

  always_comb begin
    scratch_d = scratch_q;
    if (wr_acc && (address == 3'd4)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) scratch_q <= 32'd0;
    else          scratch_q <= scratch_d;
  end

  assign scratch_rd = scratch_q;
`else
  logic unused_wr;
  assign unused_wr  = ^{writedata[31:1], byteenable[3:1]};
  assign scratch_rd = 32'd0;
`endif

  always_comb begin
    case (address)
      3'd0:    rd_mux = ID_VALUE;
      3'd1:    rd_mux = TIMESTAMP;
      3'd2:    rd_mux = uptime_q[31:0];
      3'd3:    rd_mux = hi_shadow_q;
      3'd4:    rd_mux = scratch_rd;
      default: rd_mux = 32'd0;
    endcase
  end

  // Data stages only load alongside a valid, so readdata holds the last returned word.
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             data_q [READ_LATENCY];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= 32'd0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) data_q[0] <= rd_mux;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign readdata      = data_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_uptime_slave.sv
// Bench for sysid_uptime_slave: two instances (LAT=1/PRESCALE=1 and LAT=3/PRESCALE=4)
// on a shared bus, checked against a cycle-count uptime model plus literal expectations.
module tb_sysid_uptime_slave;

  localparam logic [31:0] ID3 = 32'h1234ABCD;
  localparam logic [31:0] TS3 = 32'h5EED0001;
  localparam longint unsigned PRE [2] = '{64'd1, 64'd4};
  localparam longint unsigned LAT [2] = '{64'd1, 64'd3};
  localparam logic [31:0] IDS [2] = '{32'hCAFE0001, ID3};
  localparam logic [31:0] TSS [2] = '{32'd0, TS3};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  byteenable = 4'd0;
  logic [31:0] rd1, rd3;
  logic        dv1, dv3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sysid_uptime_slave #(
    .ID_VALUE(32'hCAFE0001), .TIMESTAMP(32'd0), .READ_LATENCY(1), .PRESCALE(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rd1), .readdatavalid(dv1)
  );

  sysid_uptime_slave #(
    .ID_VALUE(ID3), .TIMESTAMP(TS3), .READ_LATENCY(3), .PRESCALE(4)
  ) dut3 (
    .clock(clock), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rd3), .readdatavalid(dv3)
  );

  // Model: uptime is simply elapsed clocks since the last zeroing point divided by PRESCALE.
  typedef struct {
    longint unsigned due;
    logic [31:0]     data;
  } exp_t;

  exp_t            q0[$];
  exp_t            q1[$];
  longint unsigned k = 0;
  longint unsigned zero_k [2] = '{64'd0, 64'd0};
  logic [31:0]     shadow [2] = '{32'd0, 32'd0};
  logic [31:0]     scratch [2] = '{32'd0, 32'd0};
  logic            ovr_en = 1'b0;
  longint unsigned ovr_val = 0;

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      longint unsigned up;
      logic [31:0]     d;
      exp_t            e;
      if (!reset_n) begin
        zero_k[i]  = k + 1;
        shadow[i]  = 32'd0;
        scratch[i] = 32'd0;
      end else begin
        up = (ovr_en && i == 0) ? ovr_val : (k - zero_k[i]) / PRE[i];
        if (chipselect && read) begin
          case (address)
            3'd0: d = IDS[i];
            3'd1: d = TSS[i];
            3'd2: d = up[31:0];
            3'd3: d = shadow[i];
`ifdef SYSID_SCRATCH_EN
            3'd4: d = scratch[i];
`endif
            default: d = 32'd0;
          endcase
          if (address == 3'd2) shadow[i] = up[63:32];
          e.due  = k + LAT[i];
          e.data = d;
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
        end else if (chipselect && write) begin
          if (address == 3'd5 && byteenable[0] && writedata[0]) zero_k[i] = k + 1;
          if (address == 3'd4) begin
            for (int b = 0; b < 4; b++) begin
              if (byteenable[b]) scratch[i][8*b +: 8] = writedata[8*b +: 8];
            end
          end
        end
      end
    end
    k++;
  end

  always @(negedge reset_n) begin
    q0.delete();
    q1.delete();
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic        ev, av;
      logic [31:0] ed, ad;
      ev = 1'b0;
      ed = 32'd0;
      if (i == 0) begin
        av = dv1;
        ad = rd1;
        if (q0.size() > 0 && q0[0].due == k) begin
          ev = 1'b1;
          ed = q0[0].data;
          void'(q0.pop_front());
        end
      end else begin
        av = dv3;
        ad = rd3;
        if (q1.size() > 0 && q1[0].due == k) begin
          ev = 1'b1;
          ed = q1[0].data;
          void'(q1.pop_front());
        end
      end
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL model_valid dut%0d cycle %0d: got %b expected %b", i, k, av, ev);
      end
      if (ev) begin
        checks++;
        if (ad !== ed) begin
          errors++;
          $display("FAIL model_data dut%0d cycle %0d: got %h expected %h", i, k, ad, ed);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called and returns in the slot 2 time units after a rising edge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd; byteenable = be;
    @(posedge clock); #2;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd_only(input logic [2:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clock); #2;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [2:0] a,
                             input logic [31:0] e1, input logic [31:0] e3);
    logic        got1, got3;
    logic [31:0] v1, v3;
    got1 = 1'b0; got3 = 1'b0; v1 = 32'd0; v3 = 32'd0;
    rd_only(a);
    repeat (5) begin
      @(negedge clock);
      if (dv1 && !got1) begin got1 = 1'b1; v1 = rd1; end
      if (dv3 && !got3) begin got3 = 1'b1; v3 = rd3; end
    end
    if (!got1) begin
      checks++; errors++;
      $display("FAIL %s dut1: got no readdatavalid expected %h", name, e1);
    end else chk({name, " dut1"}, v1, e1);
    if (!got3) begin
      checks++; errors++;
      $display("FAIL %s dut3: got no readdatavalid expected %h", name, e3);
    end else chk({name, " dut3"}, v3, e3);
    @(posedge clock); #2;
  endtask

  initial begin
    logic [31:0] scr_exp;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_dv1", {31'd0, dv1}, 32'd0);
    chk("reset_rd3", rd3, 32'd0);
    chk("reset_dv3", {31'd0, dv3}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #2;

    expect_read("id", 3'd0, 32'hCAFE0001, ID3);
    expect_read("timestamp", 3'd1, 32'd0, TS3);

    // Back-to-back reads stream through the 3-deep pipeline in order.
    chipselect = 1'b1; read = 1'b1; address = 3'd0;
    @(posedge clock); #2; address = 3'd1;
    @(posedge clock); #2; address = 3'd0;
    @(posedge clock); #2; chipselect = 1'b0; read = 1'b0;
    @(negedge clock); chk("b2b_v0", {31'd0, dv3}, 32'd1); chk("b2b_d0", rd3, ID3);
    @(negedge clock); chk("b2b_v1", {31'd0, dv3}, 32'd1); chk("b2b_d1", rd3, TS3);
    @(negedge clock); chk("b2b_v2", {31'd0, dv3}, 32'd1); chk("b2b_d2", rd3, ID3);
    @(negedge clock); chk("b2b_end", {31'd0, dv3}, 32'd0);
    @(posedge clock); #2;

    do_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    do_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    expect_read("ro_id", 3'd0, 32'hCAFE0001, ID3);

    do_write(3'd5, 32'd1, 4'hF);
    expect_read("clear_then_read", 3'd2, 32'd0, 32'd0);

    do_write(3'd5, 32'd1, 4'hF);
    repeat (40) @(posedge clock);
    #2;
    expect_read("uptime_40", 3'd2, 32'd40, 32'd10);
    expect_read("hi_after_40", 3'd3, 32'd0, 32'd0);

`ifdef SYSID_SCRATCH_EN
    scr_exp = 32'h12BB56DD;
`else
    scr_exp = 32'd0;
`endif
    do_write(3'd4, 32'h12345678, 4'b1111);
    do_write(3'd4, 32'hAABBCCDD, 4'b0101);
    expect_read("scratch", 3'd4, scr_exp, scr_exp);

    // CTRL writes that must not clear: byte lane 0 disabled, bit0 low.
    do_write(3'd5, 32'd1, 4'b1110);
    do_write(3'd5, 32'hFFFF_FFFE, 4'hF);
    repeat (3) rd_only(3'd2);

    // Read and write together: read serviced, clear ignored.
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 3'd5; writedata = 32'd1;
    byteenable = 4'hF;
    @(posedge clock); #2;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    repeat (4) rd_only(3'd2);

    for (int a = 0; a < 8; a++) rd_only(3'(a));
    repeat (4) @(posedge clock);
    #2;

    // Carry safety: low word all-ones, then the live high word bumps before the shadow read.
    force dut1.uptime_q = 64'h0000_0000_FFFF_FFFF;
    ovr_en = 1'b1; ovr_val = 64'h0000_0000_FFFF_FFFF;
    chipselect = 1'b1; read = 1'b1; address = 3'd2;
    @(posedge clock); #2;
    release dut1.uptime_q;
    force dut1.uptime_q = 64'h0000_0001_0000_0004;
    ovr_val = 64'h0000_0001_0000_0004;
    address = 3'd3;
    @(negedge clock); chk("carry_lo", rd1, 32'hFFFF_FFFF);
    @(posedge clock); #2;
    release dut1.uptime_q;
    read = 1'b0; write = 1'b1; address = 3'd5; writedata = 32'd1; byteenable = 4'hF;
    @(negedge clock);
    chk("carry_hi_v", {31'd0, dv1}, 32'd1);
    chk("carry_hi", rd1, 32'd0);
    @(posedge clock); #2;
    ovr_en = 1'b0; chipselect = 1'b0; write = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    repeat (2) rd_only(3'd2);
    repeat (4) @(posedge clock);
    #2;

    // Reset with reads in flight: nothing may emerge.
    chipselect = 1'b1; read = 1'b1; address = 3'd0;
    @(posedge clock); #2;
    chipselect = 1'b0; read = 1'b0; reset_n = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("reset_in_flight", {31'd0, dv3}, 32'd0);
    end
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #2;
    expect_read("post_reset", 3'd2, 32'd1, 32'd0);

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
